rng_share_arbiter: RTL and testbench
====================================

# rng_share_arbiter

Round-robin controller that shares one free-running 16-bit random word stream between `N_REQ` consumers (mutation/crossover units of the neuroevolution engine). Sits directly downstream of the shared LFSR generator. Enforces a post-reset warm-up period so the generator mixes away from its seed, then hands out at most one word per clock so no two consumers ever receive the same sample. Supports re-entering warm-up on demand after a generator reseed.

## Interface
- `N_REQ`, default 4, number of requesters (2..16).
- `WORD_W`, default 16, width of random word.
- `WARMUP_CYCLES`, default 32, discarded generator cycles after reset/rewarm (≥1).
- `clock`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rand_in`  in  WORD_W  generator output; a new word every clock.
- `rewarm`  in  1  one-cycle pulse; restart warm-up (e.g., after reseed).
- `req`  in  N_REQ  level request per consumer.
- `ack`  out  N_REQ  one-hot registered grant; `data_out` valid in the cycle `ack[i]` is high.
- `data_out`  out  WORD_W  registered random word for the acked consumer.
- `busy`  out  1  high while in warm-up; no grants issued.

## Operation
- FSM states: `WARM`, `RUN`. Warm-up counter width `$clog2(WARMUP_CYCLES)`, min 1 bit.
- `WARM`: counter ==0 -> `RUN`; else decrement. No grants; `ack` = 0.
- `RUN`: if eligible request exists, pick winner, register `ack` = one-hot(winner), `data_out` <= `rand_in`, pointer <= winner. Else `ack` = 0, `data_out` holds.
- Eligible: `req[i]` high AND `ack[i]` currently low (requester just acked is ignored for that edge, so a registered requester dropping `req` on seeing `ack` never gets a second word).
- Round-robin: search order pointer+1, pointer+2, … wrapping modulo `N_REQ`, ending at pointer.
- `rewarm` high at an edge: state <= `WARM`, counter <= `WARMUP_CYCLES`-1, `ack` <= 0; overrides any grant that edge. Pointer and `data_out` retained.
- `rewarm` while already in `WARM`: counter reloads.

## Timing
- Reset (async, immediate): state `WARM`, counter `WARMUP_CYCLES`-1, pointer `N_REQ`-1 (requester 0 wins first), `ack` 0, `data_out` 0, `busy` 1.
- `busy` is a registered decode of state: falls after edge `WARMUP_CYCLES` following reset release; earliest grant registered at edge `WARMUP_CYCLES`+1.
- Grant latency: `req` high at edge e (in `RUN`, eligible, winner) -> `ack` and `data_out` valid in cycle after e, for exactly one cycle.
- Throughput: one word per clock aggregate; one requester alone gets one word every two clocks.
- `data_out` is the `rand_in` sampled at the grant edge; consecutive grants carry consecutive generator words.

## Configuration
- `RNG_ARB_STATS_EN` defined: adds output `grant_total` [15:0], increments on every registered grant, saturates at 16'hFFFF, cleared only by `resetn` (not by `rewarm`).
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package `rng_arb_pkg`: FSM state enum (`WARM`, `RUN`), default `WARMUP_CYCLES`, stats counter width/saturation constant.
- Sub-module `rr_pick`: combinational round-robin picker (inputs eligible vector, pointer; outputs one-hot winner and `any`). Top holds FSM, counter, pointer, output registers.

## Test plan
- Reset, `WARMUP_CYCLES`=8, `req`=4'b0001 held -> `busy` 1 for edges 1..7, `ack` 0 through edge 8, `ack[0]` high after edge 9, `data_out` = `rand_in` sampled at edge 9.
- All four `req` held in `RUN` -> `ack` sequence 0001,0010,0100,1000,0001… every cycle, each `data_out` equals the `rand_in` of its grant edge.
- Only `req[2]` held -> `ack[2]` high on alternate cycles, 0 in between; dropping `req[2]` in an ack cycle yields no further ack.
- `rewarm` pulse during all-request streaming -> `ack` 0 from next edge, `busy` high 8 cycles, resume with requester after last-granted index.
- `resetn` low mid-stream without clock -> `ack` 0, `data_out` 0, `busy` 1 immediately; after release, requester 0 wins first.
- With `RNG_ARB_STATS_EN`, force 65 540 grants -> `grant_total` reads 16'hFFFF and holds; `rewarm` does not clear it.

Source files
------------

// File: rtl/rng_share_arbiter_pkg.sv
// rng_arb_pkg: shared types and constants for the random-word share arbiter.
package rng_arb_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam int WARMUP_CYCLES_DEF = 32;

    // Grant statistics counter (only present with RNG_ARB_STATS_EN)
    localparam int                 STATS_W   = 16;
    localparam logic [STATS_W-1:0] STATS_SAT = 16'hFFFF;

    // $clog2 with a floor of one bit, so single-value counters still exist
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rng_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches pointer+1, pointer+2, ...
// wrapping modulo N_REQ and ending at pointer itself.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             any_o
);

    // First eligible requester after the pointer wins
    always_comb begin
        int               pos;
        logic [PTR_W-1:0] idx;
        grant_o = '0;
        any_o   = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(ptr_i) + k) % N_REQ;
            idx = PTR_W'(pos);
            if (!any_o && elig_i[idx]) begin
                grant_o[idx] = 1'b1;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: hands out one word per clock from a free-running random
// stream to N_REQ consumers in round-robin order, after a warm-up period that
// lets the generator mix away from its seed.
// Optional feature macro: RNG_ARB_STATS_EN adds a saturating grant counter
// output (grant_total), cleared only by resetn.
//
// state | meaning
// ------+-------------------------------------------------------------
// WARM  | discarding generator words; counter runs down, no grants
// RUN   | granting; one eligible requester per edge, round-robin
module rng_share_arbiter
    import rng_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int WORD_W        = 16,
    parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [WORD_W-1:0]   rand_in,
    input  logic                rewarm,
    input  logic [N_REQ-1:0]    req,
    output logic [N_REQ-1:0]    ack,
    output logic [WORD_W-1:0]   data_out,
    output logic                busy
`ifdef RNG_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]  grant_total
`endif
);

    localparam int CNT_W = min1_clog2(WARMUP_CYCLES);
    localparam int PTR_W = min1_clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_RESET  = PTR_W'(N_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               busy_q;

    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   grant;
    logic               grant_any;
    logic [PTR_W-1:0]   win_idx;

    // A requester acked this cycle is skipped so a registered consumer that
    // drops req on seeing ack cannot collect a second word.
    assign elig = req & ~ack_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (grant_any)
    );

    // One-hot winner to index for the round-robin pointer
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= WARM;
        else         state_q <= state_d;
    end

    // Next state: rewarm always wins, warm-up exits once the counter is spent
    always_comb begin
        state_d = state_q;
        if (rewarm) begin
            state_d = WARM;
        end else begin
            case (state_q)
                WARM:    if (cnt_q == '0) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = WARM;
            endcase
        end
    end

    // Datapath next values: warm-up countdown, grant, sampled word, pointer
    always_comb begin
        cnt_d  = cnt_q;
        ack_d  = '0;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (rewarm) begin
            cnt_d = CNT_RELOAD;
        end else if (state_q == WARM) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end else if (grant_any) begin
            ack_d  = grant;
            data_d = rand_in;
            ptr_d  = win_idx;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= CNT_RELOAD;
            ptr_q  <= PTR_RESET;
            ack_q  <= '0;
            data_q <= '0;
            busy_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            ack_q  <= ack_d;
            data_q <= data_d;
            busy_q <= (state_d == WARM);
        end
    end

    assign ack      = ack_q;
    assign data_out = data_q;
    assign busy     = busy_q;

`ifdef RNG_ARB_STATS_EN
    logic [STATS_W-1:0] total_q, total_d;

    // Saturating count of registered grants; rewarm leaves it alone
    always_comb begin
        total_d = total_q;
        if ((|ack_d) && (total_q != STATS_SAT)) total_d = total_q + STATS_W'(1);
    end

    // Grant statistics register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) total_q <= '0;
        else         total_q <= total_d;
    end

    assign grant_total = total_q;
`endif

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Self-checking bench for rng_share_arbiter (N_REQ=4, WORD_W=16, WARMUP_CYCLES=8).
// Directed phases pin expected values by hand; a randomized phase is checked
// every cycle against a behavioural model of the grant rules.
module tb_rng_share_arbiter;

    localparam int N  = 4;
    localparam int WW = 16;
    localparam int WU = 8;

    logic          clk;
    logic          resetn;
    logic [WW-1:0] rand_in;
    logic          rewarm;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic [WW-1:0] data_out;
    logic          busy;
`ifdef RNG_ARB_STATS_EN
    logic [15:0]   grant_total;
`endif

    rng_share_arbiter #(
        .N_REQ         (N),
        .WORD_W        (WW),
        .WARMUP_CYCLES (WU)
    ) dut (
        .clock    (clk),
        .resetn   (resetn),
        .rand_in  (rand_in),
        .rewarm   (rewarm),
        .req      (req),
        .ack      (ack),
        .data_out (data_out),
        .busy     (busy)
`ifdef RNG_ARB_STATS_EN
        ,
        .grant_total (grant_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: edges of warm-up left, last granted index, last word
    bit            m_running;
    int            m_warm_left;
    int            m_last;
    logic [N-1:0]  m_ack;
    logic [WW-1:0] m_data;
    int            m_total;

    logic [WW-1:0] w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_running   = 0;
        m_warm_left = WU;
        m_last      = N - 1;
        m_ack       = '0;
        m_data      = '0;
        m_total     = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] elig;
        int           cand;
        bit           found;
        if (rewarm) begin
            m_running   = 0;
            m_warm_left = WU;
            m_ack       = '0;
        end else if (!m_running) begin
            m_warm_left = m_warm_left - 1;
            if (m_warm_left == 0) m_running = 1;
            m_ack = '0;
        end else begin
            elig  = req & ~m_ack;
            m_ack = '0;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                cand = (m_last + k) % N;
                if (!found && elig[cand]) begin
                    found       = 1;
                    m_ack[cand] = 1'b1;
                    m_data      = rand_in;
                    m_last      = cand;
                end
            end
            if (found && m_total < 65535) m_total++;
        end
    endtask

    task automatic compare_model();
        chk("ack", 32'(ack), 32'(m_ack));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("busy", 32'(busy), m_running ? 32'd0 : 32'd1);
`ifdef RNG_ARB_STATS_EN
        chk("grant_total", 32'(grant_total), 32'(m_total));
`endif
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        if (resetn) model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic async_reset_pulse();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn  = 1'b0;
        rewarm  = 1'b0;
        req     = '0;
        rand_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        compare_model();

        // Warm-up then first grant to requester 0 at edge WU+1
        req    = 4'b0001;
        resetn = 1'b1;
        for (int e = 1; e <= WU + 1; e++) begin
            rand_in = 16'($urandom);
            w       = rand_in;
            step();
            if (e <= WU - 1) chk("warm_busy", 32'(busy), 32'd1);
            if (e <= WU)     chk("warm_ack", 32'(ack), 32'd0);
            if (e == WU)     chk("busy_fall", 32'(busy), 32'd0);
            if (e == WU + 1) begin
                chk("first_ack", 32'(ack), 32'b0001);
                chk("first_data", 32'(data_out), 32'(w));
            end
        end

        // All requesters: rotate 1,2,3,0,... with consecutive words
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            rand_in = 16'($urandom);
            w       = rand_in;
            step();
            chk("rr_all_ack", 32'(ack), 32'(1) << ((j + 1) % 4));
            chk("rr_all_data", 32'(data_out), 32'(w));
        end

        // Lone requester 2: every other cycle, then drop in an ack cycle
        req = 4'b0100;
        for (int j = 0; j < 5; j++) begin
            rand_in = 16'($urandom);
            step();
            chk("lone_ack", 32'(ack), (j % 2 == 0) ? 32'b0100 : 32'd0);
        end
        req = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            rand_in = 16'($urandom);
            step();
            chk("drop_ack", 32'(ack), 32'd0);
        end

        // Stream, rewarm, resume after the last-granted index
        req = 4'b1111;
        for (int j = 0; j < 3; j++) begin
            rand_in = 16'($urandom);
            step();
            chk("pre_rewarm_ack", 32'(ack), 32'(1) << ((j + 3) % 4));
        end
        rewarm  = 1'b1;
        rand_in = 16'($urandom);
        step();
        rewarm = 1'b0;
        chk("rewarm_ack", 32'(ack), 32'd0);
        chk("rewarm_busy", 32'(busy), 32'd1);
        for (int j = 0; j < WU - 1; j++) begin
            rand_in = 16'($urandom);
            step();
            chk("rewarm_hold_busy", 32'(busy), 32'd1);
            chk("rewarm_hold_ack", 32'(ack), 32'd0);
        end
        rand_in = 16'($urandom);
        step();
        chk("rewarm_end_busy", 32'(busy), 32'd0);
        chk("rewarm_end_ack", 32'(ack), 32'd0);
        rand_in = 16'($urandom);
        step();
        chk("resume_ack", 32'(ack), 32'b0100);

        // Async reset mid-stream, then requester 0 wins first again
        rand_in = 16'($urandom);
        step();
        async_reset_pulse();
        for (int e = 1; e <= WU + 1; e++) begin
            rand_in = 16'($urandom);
            step();
        end
        chk("post_reset_ack", 32'(ack), 32'b0001);

        // Randomized traffic with occasional rewarm and reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0) req = 4'($urandom);
            rewarm  = ($urandom_range(0, 39) == 0);
            rand_in = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rewarm = 1'b0;
                async_reset_pulse();
            end else begin
                step();
            end
        end
        rewarm = 1'b0;

`ifdef RNG_ARB_STATS_EN
        // Saturate the grant counter, then confirm rewarm leaves it
        req = 4'b1111;
        for (int c = 0; c < 65540 + WU + 2; c++) begin
            rand_in = 16'($urandom);
            step();
        end
        chk("stats_sat", 32'(grant_total), 32'hFFFF);
        rewarm = 1'b1;
        step();
        rewarm = 1'b0;
        step();
        chk("stats_rewarm", 32'(grant_total), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
